// File: rtl/sync_fifo_param_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_pkg
// Shared definitions for the FIFO family (sync_fifo_param, async_fifo).
//   - clog2()          : ceiling log2 as a constant function, usable in
//                        parameter and localparam expressions.
//   - AF_TH_OFFSET     : default distance of the almost-full threshold below
//                        DEPTH.
//   - AE_TH_DEFAULT    : default almost-empty threshold.
// No ports; import with `import sync_fifo_param_pkg::*;`.
// -----------------------------------------------------------------------------
package sync_fifo_param_pkg;

  localparam int AF_TH_OFFSET  = 4;
  localparam int AE_TH_DEFAULT = 4;

  // Number of bits needed to encode values 0..value-1 (clog2(1) == 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_mem
// DATA_WIDTH x DEPTH storage for the FIFO family: one write port and one read
// port, no reset on the array itself.
//   REG_READ = 1 : r_data is a register loaded from mem[r_addr] when r_en is
//                  high and cleared by rst; one cycle of read latency.
//   REG_READ = 0 : r_data shows mem[r_addr] combinationally; rst and r_en
//                  are not used.
// Ports:
//   clk, rst        clock, async active-high reset (registered read only)
//   w_en/w_addr/w_data  write port, written on the rising edge
//   r_en/r_addr     read port control
//   r_data          read data
// -----------------------------------------------------------------------------
module sync_fifo_param_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10,
  parameter bit REG_READ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [AW-1:0]         w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  input  logic [AW-1:0]         r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      mem_q[w_addr] <= w_data;
    end
  end

  generate
    if (REG_READ) begin : g_reg_read
      logic [DATA_WIDTH-1:0] r_data_q;
      logic [DATA_WIDTH-1:0] r_data_d;

      // Non-blocking write above means a same-edge read of the address being
      // written returns the old word.
      always_comb begin
        r_data_d = r_data_q;
        if (r_en) begin
          r_data_d = mem_q[r_addr];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data_q <= '0;
        end else begin
          r_data_q <= r_data_d;
        end
      end

      assign r_data = r_data_q;
    end else begin : g_async_read
      logic unused_ctrl;
      assign unused_ctrl = rst ^ r_en;
      assign r_data      = mem_q[r_addr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO, any DEPTH >= 2, with occupancy count, almost-full /
// almost-empty thresholds and sticky overflow / underflow flags.
// Build option:
//   FIFO_FWFT_EN defined   : first-word fall-through; rData shows the head
//                            entry combinationally while !empty, rEn pops.
//   FIFO_FWFT_EN undefined : rData registered, loaded with the head word on
//                            an accepted read (1-cycle latency).
// Ports:
//   clk, rst            clock, async active-high reset
//   wEn, wData          write request and data
//   rEn, rData          read request and data
//   full, empty         count == DEPTH / count == 0
//   almostFull          count >= AF_TH
//   almostEmpty         count <= AE_TH
//   count               current occupancy (CW bits)
//   overflow, underflow sticky: a write / read was rejected
// -----------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  parameter  int AF_TH      = DEPTH - AF_TH_OFFSET,
  parameter  int AE_TH      = AE_TH_DEFAULT,
  localparam int CW         = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wEn,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic                  rEn,
  output logic [DATA_WIDTH-1:0] rData,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            PW       = clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

`ifdef FIFO_FWFT_EN
  localparam bit REG_READ = 1'b0;
`else
  localparam bit REG_READ = 1'b1;
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_ok;
  logic          wr_ok;

  // Acceptance uses only pre-edge flags. A write into a full FIFO is allowed
  // when a read frees a slot in the same cycle; the reverse (read of an empty
  // FIFO covered by a same-cycle write) is not.
  always_comb begin
    rd_ok = rEn && !empty_q;
    wr_ok = wEn && (!full_q || rd_ok);

    // Explicit wrap so non-power-of-two depths work.
    wr_ptr_d = wr_ptr_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    rd_ptr_d = rd_ptr_q;
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end

    // Flags follow the next count so they change on the same edge as count.
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (int'(count_d) >= AF_TH);
    ae_d    = (int'(count_d) <= AE_TH);

    ovf_d = ovf_q | (wEn & ~wr_ok);
    unf_d = unf_q | (rEn & ~rd_ok);
  end

  // almostFull at reset applies the count >= AF_TH rule to count == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_TH <= 0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_param_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW),
    .REG_READ   (REG_READ)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .w_en   (wr_ok),
    .w_addr (wr_ptr_q),
    .w_data (wData),
    .r_en   (rd_ok),
    .r_addr (rd_ptr_q),
    .r_data (rData)
  );

  assign full        = full_q;
  assign empty       = empty_q;
  assign almostFull  = af_q;
  assign almostEmpty = ae_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Two instances of sync_fifo_param (DATA_WIDTH 8):
//   dutA : DEPTH 6 (non power of two), default thresholds AF_TH 2, AE_TH 4
//   dutB : DEPTH 16, AF_TH 12, AE_TH 3
// Directed sequences followed by randomized traffic, checked each cycle
// against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wEn         [2];
  logic [DW-1:0] wData       [2];
  logic          rEn         [2];
  logic [DW-1:0] rData       [2];
  logic          full        [2];
  logic          empty       [2];
  logic          almostFull  [2];
  logic          almostEmpty [2];
  logic          overflow    [2];
  logic          underflow   [2];
  logic [2:0]    countA;
  logic [4:0]    countB;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per FIFO holding the stored words in order.
  logic [DW-1:0] modelA [$];
  logic [DW-1:0] modelB [$];
  bit            expOvf   [2];
  bit            expUnf   [2];
  logic [DW-1:0] expRData [2];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(6)) dutA (
    .clk(clk), .rst(rst), .wEn(wEn[0]), .wData(wData[0]), .rEn(rEn[0]),
    .rData(rData[0]), .full(full[0]), .empty(empty[0]),
    .almostFull(almostFull[0]), .almostEmpty(almostEmpty[0]),
    .count(countA), .overflow(overflow[0]), .underflow(underflow[0])
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(16), .AF_TH(12), .AE_TH(3)) dutB (
    .clk(clk), .rst(rst), .wEn(wEn[1]), .wData(wData[1]), .rEn(rEn[1]),
    .rData(rData[1]), .full(full[1]), .empty(empty[1]),
    .almostFull(almostFull[1]), .almostEmpty(almostEmpty[1]),
    .count(countB), .overflow(overflow[1]), .underflow(underflow[1])
  );

  // Per-instance configuration as seen by the model.
  function automatic int depthOf(input int s);
    return (s == 0) ? 6 : 16;
  endfunction

  function automatic int afOf(input int s);
    return (s == 0) ? 2 : 12;
  endfunction

  function automatic int aeOf(input int s);
    return (s == 0) ? 4 : 3;
  endfunction

  function automatic int modelSize(input int s);
    return (s == 0) ? modelA.size() : modelB.size();
  endfunction

  function automatic string nameOf(input int s);
    return (s == 0) ? "A" : "B";
  endfunction

  // The single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Compares every output of one instance with the model's view of it.
  task automatic checkAll(input int s);
    int            n;
    logic [31:0]   cnt;
    logic [DW-1:0] head;
    n    = modelSize(s);
    cnt  = (s == 0) ? 32'(countA) : 32'(countB);
    head = '0;
    if (n > 0) head = (s == 0) ? modelA[0] : modelB[0];
    checkOutput({nameOf(s), ".count"},       cnt,                  32'(n));
    checkOutput({nameOf(s), ".full"},        32'(full[s]),         32'(n == depthOf(s)));
    checkOutput({nameOf(s), ".empty"},       32'(empty[s]),        32'(n == 0));
    checkOutput({nameOf(s), ".almostFull"},  32'(almostFull[s]),   32'(n >= afOf(s)));
    checkOutput({nameOf(s), ".almostEmpty"}, 32'(almostEmpty[s]),  32'(n <= aeOf(s)));
    checkOutput({nameOf(s), ".overflow"},    32'(overflow[s]),     32'(expOvf[s]));
    checkOutput({nameOf(s), ".underflow"},   32'(underflow[s]),    32'(expUnf[s]));
`ifdef FIFO_FWFT_EN
    if (n > 0) checkOutput({nameOf(s), ".rData"}, 32'(rData[s]), 32'(head));
`else
    checkOutput({nameOf(s), ".rData"}, 32'(rData[s]), 32'(expRData[s]));
`endif
  endtask

  // Advances the model by one clock using the FIFO's acceptance rules
  // applied to the occupancy before the edge.
  task automatic modelStep(input int s, input bit we, input logic [DW-1:0] wd,
                           input bit re);
    int n;
    bit rdAcc;
    bit wrAcc;
    n     = modelSize(s);
    rdAcc = re && (n > 0);
    wrAcc = we && ((n < depthOf(s)) || rdAcc);
    if (rdAcc) begin
      if (s == 0) expRData[0] = modelA.pop_front();
      else        expRData[1] = modelB.pop_front();
    end
    if (wrAcc) begin
      if (s == 0) modelA.push_back(wd);
      else        modelB.push_back(wd);
    end
    if (we && !wrAcc) expOvf[s] = 1'b1;
    if (re && !rdAcc) expUnf[s] = 1'b1;
  endtask

  task automatic resetModel();
    modelA.delete();
    modelB.delete();
    for (int s = 0; s < 2; s++) begin
      expOvf[s]   = 1'b0;
      expUnf[s]   = 1'b0;
      expRData[s] = '0;
    end
  endtask

  // Drives one cycle of requests on one instance, then checks it 1 unit
  // after the rising edge.
  task automatic applyStimulus(input int s, input bit we,
                               input logic [DW-1:0] wd, input bit re);
    wEn[s]   = we;
    wData[s] = wd;
    rEn[s]   = re;
    modelStep(s, we, wd, re);
    @(posedge clk);
    #1;
    wEn[s] = 1'b0;
    rEn[s] = 1'b0;
    checkAll(s);
  endtask

  // Raises reset between edges and checks that both instances clear without
  // waiting for a clock, then releases it and checks again after one edge.
  task automatic pulseReset();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      wEn[s] = 1'b0;
      rEn[s] = 1'b0;
    end
    rst = 1'b1;
    resetModel();
    #1;
    checkAll(0);
    checkAll(1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkAll(0);
    checkAll(1);
  endtask

  // Main sequence: directed scenarios, then randomized traffic.
  initial begin
    for (int s = 0; s < 2; s++) begin
      wEn[s]   = 1'b0;
      wData[s] = '0;
      rEn[s]   = 1'b0;
    end
    resetModel();

    // Reset and idle.
    pulseReset();
    applyStimulus(0, 1'b0, '0, 1'b0);
    applyStimulus(1, 1'b0, '0, 1'b0);

    // Fill the depth-6 FIFO, overflow it with 0xFF, drain, then underflow.
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1, DW'(8'hA0 + i), 1'b0);
    applyStimulus(0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'b0, '0, 1'b1);
    applyStimulus(0, 1'b0, '0, 1'b1);

    // Repeated write-4 / read-4 so the pointers wrap past 5.
    pulseReset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, DW'(16 * r + i + 1), 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, '0, 1'b1);
    end

    // Full FIFO with simultaneous read and write: stays full, no overflow.
    pulseReset();
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1, DW'(8'h30 + i), 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1'b1, DW'($urandom), 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'b0, '0, 1'b1);

    // Read and write together on an empty FIFO: read rejected, write kept.
    pulseReset();
    applyStimulus(1, 1'b1, 8'h5C, 1'b1);
    applyStimulus(1, 1'b0, '0, 1'b1);

    // Threshold crossings on the depth-16 FIFO, then reset at count 9.
    pulseReset();
    for (int i = 0; i < 12; i++) applyStimulus(1, 1'b1, DW'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1'b1, DW'(8'hD0 + i), 1'b0);
    pulseReset();
    applyStimulus(1, 1'b1, 8'h77, 1'b0);
    applyStimulus(1, 1'b0, '0, 1'b1);

    // Randomized traffic, alternating write-heavy and read-heavy phases so
    // both full and empty are visited repeatedly.
    pulseReset();
    for (int s = 0; s < 2; s++) begin
      for (int phase = 0; phase < 6; phase++) begin
        int wProb;
        wProb = (phase % 2 == 0) ? 80 : 25;
        for (int i = 0; i < 50; i++) begin
          applyStimulus(s, $urandom_range(0, 99) < wProb, DW'($urandom),
                        $urandom_range(0, 99) < (100 - wProb));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
